mdu: RTL
========

MDU -- requirements
Module: mdu

Interface
REQ-001 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The module SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-003 The module SHALL have port EX_MDOp, input, 3 bits: the EX-stage HI/LO operation code (codes in REQ-010).
REQ-004 The module SHALL have port EX_A, input, 32 bits: the rs operand after bypass.
REQ-005 The module SHALL have port EX_B, input, 32 bits: the rt operand after bypass.
REQ-006 The module SHALL have port EX_stall, input, 1 bit: EX is frozen this cycle (dcache_stall).
REQ-007 The module SHALL have port MEM1_flush, input, 1 bit: MEM1 exception or eret flush.
REQ-008 The module SHALL have port isbusy, output, 1 bit: a multiply or divide is in progress; it feeds the stall unit.
REQ-009 The module SHALL have ports HI and LO, output, 32 bits each: the architectural HI/LO registers.

Function
REQ-010 EX_MDOp SHALL be encoded as: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo; codes 7 and above SHALL be treated as none.
REQ-011 An op SHALL be accepted at a rising edge only when EX_MDOp is nonzero, EX_stall is 0, MEM1_flush is 0 and the state is IDLE; in any other case EX_MDOp SHALL be ignored.
REQ-012 The FSM SHALL have states IDLE, MUL and DIV, and isbusy SHALL equal (state != IDLE), driven from a register.
REQ-013 mthi and mtlo SHALL write EX_A into HI or LO respectively at the accepting edge, with the state remaining IDLE.
REQ-014 When mthi/mtlo arrives while busy, it SHALL be ignored, and the bench SHALL flag it as a protocol violation.
REQ-015 mult/multu acceptance SHALL latch the operands and enter MUL; the first MUL cycle SHALL register four 16x16 partial products; the second SHALL sum them.
REQ-016 At the end of the second MUL cycle, {HI,LO} SHALL be written with the 64-bit product and the state SHALL return to IDLE; isbusy SHALL be high for exactly 2 cycles.
REQ-017 mult SHALL treat operands as two's complement; multu SHALL treat them as unsigned.
REQ-018 div/divu acceptance SHALL latch the operand magnitudes and signs and enter DIV.
REQ-019 DIV SHALL perform 32 radix-2 restoring iterations followed by 1 sign-fix cycle; isbusy SHALL be high for exactly 33 cycles.
REQ-020 HI/LO SHALL be written on the final DIV edge.
REQ-021 Signed divide: the quotient SHALL be negative iff the operand signs differ, and the remainder SHALL take the sign of the dividend.
REQ-022 Signed divide of 0x80000000 by 0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
REQ-023 Divisor zero (signed or unsigned) SHALL complete with normal latency and give HI=EX_A as latched and LO=0xFFFFFFFF.
REQ-024 MEM1_flush=1 while busy SHALL abort the operation at that edge: state returns to IDLE, HI/LO are unchanged, and isbusy is 0 in the next cycle.
REQ-025 If flush and completion coincide, the flush SHALL win and HI/LO SHALL stay unchanged.
REQ-026 EX_stall SHALL NOT pause an operation in progress.
REQ-027 HI and LO SHALL be driven directly from the registers; a new value SHALL be visible in the cycle after the writing edge.
REQ-028 A new op SHALL be acceptable in the first cycle after completion (the cycle in which isbusy is 0).

Reset
REQ-029 rst_n=0 at a rising edge SHALL force the state to IDLE and set isbusy=0, HI=0, LO=0, and clear the iteration counter and datapath registers, including mid-operation.
REQ-030 Ops presented in the cycle rst_n is low SHALL be discarded.

Structure
REQ-031 A shared package mdu_pkg SHALL hold the EX_MDOp encodings, the FSM state enum, MUL_CYCLES=2 and DIV_CYCLES=33.
REQ-032 The divider SHALL be a sub-module div_core, with ports: start, signed flag, operands, abort, done, quotient, remainder.
REQ-033 mdu SHALL own the FSM, the multiplier and the HI/LO registers.

Verification
REQ-034 mult with A=0xFFFFFFFD, B=7 -> isbusy high 2 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFEB.
REQ-035 multu with A=0xFFFFFFFF, B=2 -> HI=0x00000001, LO=0xFFFFFFFE.
REQ-036 div with A=0xFFFFFFF9 (-7), B=2 -> isbusy high exactly 33 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-037 divu with A=100, B=0 -> HI=0x00000064, LO=0xFFFFFFFF.
REQ-038 divu with A=1000, B=7, MEM1_flush pulsed at busy cycle 10 -> isbusy low the next cycle, HI/LO unchanged; mtlo A=0x55 next cycle -> LO=0x55.
REQ-039 mult presented with EX_stall=1 -> not accepted and isbusy stays 0; rst_n low during busy cycle 20 of a div -> HI=LO=0, isbusy=0.

Source files
------------

// File: rtl/mdu_pkg.sv
// HI/LO multiply-divide unit: shared encodings, FSM states and cycle counts.
// Latency: MUL_CYCLES for mult/multu, DIV_CYCLES for div/divu, mthi/mtlo in the accepting edge.
// Backpressure: none; the unit exposes isbusy and ignores ops while busy.
package mdu_pkg;

   // EX_MDOp encodings; codes above MD_MTLO decode as no operation.
   localparam logic [2:0] MD_NONE  = 3'd0;
   localparam logic [2:0] MD_MULT  = 3'd1;
   localparam logic [2:0] MD_MULTU = 3'd2;
   localparam logic [2:0] MD_DIV   = 3'd3;
   localparam logic [2:0] MD_DIVU  = 3'd4;
   localparam logic [2:0] MD_MTHI  = 3'd5;
   localparam logic [2:0] MD_MTLO  = 3'd6;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2
   } state_t;

   // Busy-cycle counts: MUL = partial products + sum,
   // DIV = 32 restoring iterations + 1 sign-fix cycle.
   localparam int MUL_CYCLES = 2;
   localparam int DIV_CYCLES = 33;

endpackage

// File: rtl/mdu_div_core.sv
// Radix-2 restoring divider on operand magnitudes with a final sign-fix cycle.
// Latency: start edge + DIV_CYCLES busy cycles; done is high during the last one.
// Backpressure: none; abort drops the operation, start is honoured only when the caller is idle.
// Ports: clk, rst_n (sync, active low), start, sgn (signed divide), a (dividend),
//        b (divisor), abort, done, quotient, remainder (valid while done is high).
module div_core
   import mdu_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        sgn,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        abort,
   output logic        done,
   output logic [31:0] quotient,
   output logic [31:0] remainder
);

   localparam logic [5:0] LAST_STEP = 6'(DIV_CYCLES - 1);

   logic        active;
   logic [5:0]  cnt;
   logic [31:0] quo;       // dividend shifting out at the top, quotient bits shifting in
   logic [31:0] rem;
   logic [31:0] dvs;
   logic        q_neg;
   logic        r_neg;
   logic        dvs_zero;
   logic [32:0] rem_sh;
   logic [32:0] diff;

   assign rem_sh = {rem, quo[31]};
   assign diff   = rem_sh - {1'b0, dvs};   // bit 32 set means the trial subtract borrowed
   assign done   = active && (cnt == LAST_STEP);

   // Sign-fix happens combinationally in the final cycle. A zero divisor leaves
   // the magnitude loop producing all-ones and rem = |a|; re-signing rem gives
   // back the original dividend, so only the quotient needs overriding.
   assign quotient  = dvs_zero ? 32'hFFFF_FFFF : (q_neg ? -quo : quo);
   assign remainder = r_neg ? -rem : rem;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         active   <= 1'b0;
         cnt      <= '0;
         quo      <= '0;
         rem      <= '0;
         dvs      <= '0;
         q_neg    <= 1'b0;
         r_neg    <= 1'b0;
         dvs_zero <= 1'b0;
      end else if (start) begin
         active   <= 1'b1;
         cnt      <= '0;
         quo      <= (sgn && a[31]) ? -a : a;
         rem      <= '0;
         dvs      <= (sgn && b[31]) ? -b : b;
         q_neg    <= sgn && (a[31] ^ b[31]);
         r_neg    <= sgn && a[31];
         dvs_zero <= (b == 32'h0);
      end else if (abort || done) begin
         active <= 1'b0;
      end else if (active) begin
         cnt <= cnt + 6'd1;
         if (!diff[32]) begin
            rem <= diff[31:0];
            quo <= {quo[30:0], 1'b1};
         end else begin
            rem <= rem_sh[31:0];
            quo <= {quo[30:0], 1'b0};
         end
      end
   end

endmodule

// File: rtl/mdu.sv
// HI/LO multiply-divide unit for the EX stage: FSM, 2-cycle multiplier, HI/LO registers.
// Latency: mthi/mtlo at the accepting edge; mult 2 busy cycles; div 33 busy cycles.
// Backpressure: isbusy (registered) stalls the pipe; ops arriving while busy, stalled or flushed are dropped.
// Ports: clk, rst_n (sync, active low), EX_MDOp/EX_A/EX_B (op and bypassed operands),
//        EX_stall (EX frozen), MEM1_flush (abort), isbusy, HI, LO (architectural registers).
module mdu
   import mdu_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [2:0]  EX_MDOp,
   input  logic [31:0] EX_A,
   input  logic [31:0] EX_B,
   input  logic        EX_stall,
   input  logic        MEM1_flush,
   output logic        isbusy,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   localparam logic MUL_LAST = 1'(MUL_CYCLES - 1);

   state_t      state;
   state_t      state_nxt;
   logic        accept;
   logic        op_mul;
   logic        op_div;
   logic        mul_cnt;
   logic        mul_last;
   logic [31:0] ma;
   logic [31:0] mb;
   logic        m_sgn;
   logic [31:0] pp_ll, pp_lh, pp_hl, pp_hh;
   logic [31:0] sign_corr;
   logic [63:0] product;
   logic        div_done;
   logic [31:0] div_q;
   logic [31:0] div_r;

   assign accept   = (state == ST_IDLE) && !EX_stall && !MEM1_flush;
   assign op_mul   = accept && (EX_MDOp == MD_MULT || EX_MDOp == MD_MULTU);
   assign op_div   = accept && (EX_MDOp == MD_DIV  || EX_MDOp == MD_DIVU);
   assign mul_last = (mul_cnt == MUL_LAST);

   // Unsigned 64-bit product from the four partials; for two's-complement operands
   // a set sign bit contributes -2^32 * other operand, subtracted in the upper word.
   assign sign_corr = ((m_sgn && ma[31]) ? mb : 32'h0) + ((m_sgn && mb[31]) ? ma : 32'h0);
   assign product   = {pp_hh, 32'h0}
                    + {16'h0, pp_lh, 16'h0}
                    + {16'h0, pp_hl, 16'h0}
                    + {32'h0, pp_ll}
                    - {sign_corr, 32'h0};

   div_core u_div (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (op_div),
      .sgn       (EX_MDOp == MD_DIV),
      .a         (EX_A),
      .b         (EX_B),
      .abort     (MEM1_flush && (state == ST_DIV)),
      .done      (div_done),
      .quotient  (div_q),
      .remainder (div_r)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (op_mul)      state_nxt = ST_MUL;
            else if (op_div) state_nxt = ST_DIV;
         end
         ST_MUL:  if (MEM1_flush || mul_last) state_nxt = ST_IDLE;
         ST_DIV:  if (MEM1_flush || div_done) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         isbusy  <= 1'b0;
         HI      <= '0;
         LO      <= '0;
         mul_cnt <= 1'b0;
         ma      <= '0;
         mb      <= '0;
         m_sgn   <= 1'b0;
         pp_ll   <= '0;
         pp_lh   <= '0;
         pp_hl   <= '0;
         pp_hh   <= '0;
      end else begin
         state  <= state_nxt;
         isbusy <= (state_nxt != ST_IDLE);

         if (op_mul) begin
            ma    <= EX_A;
            mb    <= EX_B;
            m_sgn <= (EX_MDOp == MD_MULT);
         end

         if (state == ST_MUL && !MEM1_flush && !mul_last) mul_cnt <= mul_cnt + 1'b1;
         else                                             mul_cnt <= 1'b0;

         if (state == ST_MUL && mul_cnt == 1'b0) begin
            pp_ll <= {16'h0, ma[15:0]}  * {16'h0, mb[15:0]};
            pp_lh <= {16'h0, ma[15:0]}  * {16'h0, mb[31:16]};
            pp_hl <= {16'h0, ma[31:16]} * {16'h0, mb[15:0]};
            pp_hh <= {16'h0, ma[31:16]} * {16'h0, mb[31:16]};
         end

         if (accept && EX_MDOp == MD_MTHI) HI <= EX_A;
         if (accept && EX_MDOp == MD_MTLO) LO <= EX_A;

         // A flush in the completing cycle wins: HI/LO keep their old values.
         if (state == ST_MUL && mul_last && !MEM1_flush) begin
            HI <= product[63:32];
            LO <= product[31:0];
         end
         if (state == ST_DIV && div_done && !MEM1_flush) begin
            HI <= div_r;
            LO <= div_q;
         end
      end
   end

endmodule
